// File: rtl/abro_arb_pkg.sv
// rtl/abro_arb_pkg.sv - shared state encodings and parameter defaults for the ABRO event arbiter
package abro_arb_pkg;

  localparam int N_DEFAULT       = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_REARM = 2'b10
  } arb_state_t;

endpackage

// File: rtl/abro_event_arbiter_if.sv
// rtl/abro_event_arbiter_if.sv - service-port bundle between ABRO channels, arbiter and consumer
interface abro_event_arbiter_if
  import abro_arb_pkg::*;
#(
  parameter int N = N_DEFAULT
) ();

  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         ack;
  logic         valid;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic [N-1:0] rearm;
  logic [1:0]   state;
  logic         error;

  // Driver side: ABRO machines plus the consumer
  modport master (
    output req, ack,
    input  valid, grant, grant_id, rearm, state, error
  );

  // Arbiter side
  modport slave (
    input  req, ack,
    output valid, grant, grant_id, rearm, state, error
  );

endinterface

// File: rtl/abro_rr_picker.sv
// rtl/abro_rr_picker.sv - combinational round-robin search for the first pending channel at or above ptr
module abro_rr_picker
  import abro_arb_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  // Channel visited k steps after ptr, wrapping N-1 back to 0
  function automatic logic [W-1:0] slot(input logic [W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[W-1:0];
  endfunction

  // Walk the ring starting at ptr; the first pending channel wins
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && pending[slot(ptr, k)]) begin
        found = 1'b1;
        index = slot(ptr, k);
      end
    end
  end

endmodule

// File: rtl/abro_event_arbiter.sv
// rtl/abro_event_arbiter.sv - round-robin arbiter for N ABRO channels; ABRO_ARB_TIMEOUT_EN adds an Ack timeout
module abro_event_arbiter
  import abro_arb_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  abro_event_arbiter_if.slave bus
);

  localparam int W = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_params
    $error("abro_event_arbiter: N must be 2..16 and TIMEOUT at least 1");
  end

  arb_state_t   state_q;
  logic [N-1:0] req_prev;
  logic [N-1:0] pending;
  logic [N-1:0] grant_q;
  logic [N-1:0] rearm_q;
  logic [W-1:0] grant_id_q;
  logic [W-1:0] cur_id;
  logic [W-1:0] ptr;
  logic         valid_q;

  logic [N-1:0] rise;
  logic [N-1:0] clear_mask;
  logic [N-1:0] pending_next;
  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic [W-1:0] ptr_next;
  logic         timeout_hit;

  // A new edge on the serviced channel in the REARM cycle is OR-ed in after the clear, so it survives
  assign rise         = bus.req & ~req_prev;
  assign clear_mask   = (state_q == ST_REARM) ? rearm_q : '0;
  assign pending_next = (pending & ~clear_mask) | rise;
  assign ptr_next     = (cur_id == W'(N - 1)) ? '0 : cur_id + 1'b1;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] i);
    return {{(N - 1){1'b0}}, 1'b1} << i;
  endfunction

  abro_rr_picker #(.N(N), .W(W)) u_picker (
    .pending (pending),
    .ptr     (ptr),
    .found   (pick_found),
    .index   (pick_idx)
  );

`ifdef ABRO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;
  logic          error_q;

  assign timeout_hit = (state_q == ST_GRANT) && !bus.ack && (to_cnt == CW'(TIMEOUT - 1));
  assign bus.error   = error_q;

  // Count unacknowledged GRANT cycles; expiry forces REARM and latches the sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      error_q <= 1'b0;
    end else if (state_q == ST_GRANT && !bus.ack) begin
      if (timeout_hit) begin
        to_cnt  <= '0;
        error_q <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus.error   = 1'b0;
`endif

  // Edge capture, pending bookkeeping and the IDLE/GRANT/REARM sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_prev   <= '0;
      pending    <= '0;
      grant_q    <= '0;
      rearm_q    <= '0;
      grant_id_q <= '0;
      cur_id     <= '0;
      ptr        <= '0;
      valid_q    <= 1'b0;
    end else begin
      req_prev <= bus.req;
      pending  <= pending_next;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            state_q    <= ST_GRANT;
            cur_id     <= pick_idx;
            valid_q    <= 1'b1;
            grant_q    <= onehot(pick_idx);
            grant_id_q <= pick_idx;
          end
        end
        ST_GRANT: begin
          if (bus.ack || timeout_hit) begin
            state_q    <= ST_REARM;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            grant_id_q <= '0;
            rearm_q    <= grant_q;
          end
        end
        ST_REARM: begin
          state_q <= ST_IDLE;
          rearm_q <= '0;
          ptr     <= ptr_next;
        end
        default: begin
          state_q    <= ST_IDLE;
          valid_q    <= 1'b0;
          grant_q    <= '0;
          grant_id_q <= '0;
          rearm_q    <= '0;
        end
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.rearm    = rearm_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_abro_event_arbiter.sv
// tb/tb_abro_event_arbiter.sv - self-checking bench for abro_event_arbiter
module tb_abro_event_arbiter;
  import abro_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int TO = 16;
  localparam int OW = 1 + N + W + N + 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  abro_event_arbiter_if #(.N(N)) bus ();

  abro_event_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: channel-level view of who is waiting and whose turn it is
  bit mp[N];
  bit mprev[N];
  int phase;   // 0 waiting for work, 1 channel being served, 2 channel being re-armed
  int owner;
  int mptr;
  int mwait;
  bit merr;

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic         valid;
    logic [N-1:0] grant;
    logic [W-1:0] gid;
    logic [N-1:0] rearm;
    logic [1:0]   st;
  } vec_t;

  vec_t vt[13];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mp[i]    = 1'b0;
      mprev[i] = 1'b0;
    end
    phase = 0;
    owner = 0;
    mptr  = 0;
    mwait = 0;
    merr  = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic a);
    bit rise[N];
    int pick;
    int c;
    for (int i = 0; i < N; i++) rise[i] = r[i] && !mprev[i];
    pick = -1;
    case (phase)
      0: begin
        for (int k = 0; k < N; k++) begin
          c = (mptr + k) % N;
          if (pick < 0 && mp[c]) pick = c;
        end
        if (pick >= 0) begin
          phase = 1;
          owner = pick;
          mwait = 0;
        end
      end
      1: begin
        if (a) phase = 2;
        else begin
          mwait++;
`ifdef ABRO_ARB_TIMEOUT_EN
          if (mwait == TO) begin
            phase = 2;
            merr  = 1'b1;
          end
`endif
        end
      end
      default: begin
        mp[owner] = 1'b0;
        mptr      = (owner + 1) % N;
        phase     = 0;
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (rise[i]) mp[i] = 1'b1;
      mprev[i] = r[i];
    end
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0] g;
    logic [N-1:0] rm;
    logic [W-1:0] id;
    g  = '0;
    rm = '0;
    id = '0;
    if (phase == 1) begin
      g[owner] = 1'b1;
      id       = owner[W-1:0];
    end
    if (phase == 2) rm[owner] = 1'b1;
    return {phase == 1, g, id, rm, phase[1:0], merr};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.valid, bus.grant, bus.grant_id, bus.rearm, bus.state, bus.error};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic a);
    bus.req = r;
    bus.ack = a;
    @(posedge clk);
    model_step(r, a);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    cmp("reset_outputs", 32'(obs()), 32'(0));
    rst = 1'b0;
  endtask

  task automatic rr_round(input string tag);
    int ids[$];
    logic was_valid;
    tick('0, 1'b1);
    tick(4'b1111, 1'b1);
    was_valid = bus.valid;
    for (int c = 0; c < 30 && ids.size() < 4; c++) begin
      tick(4'b1111, 1'b1);
      if (bus.valid && !was_valid) ids.push_back(int'(bus.grant_id));
      was_valid = bus.valid;
    end
    cmp({tag, "_count"}, 32'(ids.size()), 32'(4));
    foreach (ids[k]) cmp($sformatf("%s_order%0d", tag, k), 32'(ids[k]), 32'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] hold_grant;
    int cnt;

    vt[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0000, 2'd1};
    vt[3]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0000, 2'd1};
    vt[4]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 4'b0000, 2'd1};
    vt[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0100, 2'd2};
    vt[6]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[7]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[9]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};
    vt[10] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 4'b0000, 2'd1};
    vt[11] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0001, 2'd2};
    vt[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd0};

    bus.req = '0;
    bus.ack = 1'b0;

    // Quiet channels after reset
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick('0, 1'b0);
      cmp($sformatf("quiet%0d", c), 32'({bus.state, bus.valid, bus.rearm}), 32'(0));
    end

    // Single request, late ack, then wrap-around from ptr=3
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick(vt[i].req, vt[i].ack);
      cmp($sformatf("vec%0d", i),
          32'({bus.valid, bus.grant, bus.grant_id, bus.rearm, bus.state}),
          32'({vt[i].valid, vt[i].grant, vt[i].gid, vt[i].rearm, vt[i].st}));
    end

    // All four channels together, twice
    do_reset();
    rr_round("rr_a");
    rr_round("rr_b");

    // Grant ignores other request changes and waits for ack
    do_reset();
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b0);
    cmp("hold_start", 32'({bus.valid, bus.grant}), 32'({1'b1, 4'b1000}));
`ifdef ABRO_ARB_TIMEOUT_EN
    cnt = 1;
    for (int c = 0; c < 40; c++) begin
      tick({1'b1, 3'($urandom)}, 1'b0);
      if (bus.valid && bus.grant == 4'b1000) cnt++;
      else break;
    end
    cmp("timeout_cycles", 32'(cnt), 32'(TO));
    cmp("timeout_state", 32'(bus.state), 32'(ST_REARM));
    cmp("timeout_rearm", 32'(bus.rearm), 32'(4'b1000));
    cmp("timeout_error", 32'(bus.error), 32'(1));
    for (int c = 0; c < 5; c++) tick(4'b1000, 1'b0);
    cmp("error_sticky", 32'(bus.error), 32'(1));
    do_reset();
    cmp("error_cleared", 32'(bus.error), 32'(0));
`else
    hold_grant = 4'b1000;
    for (int c = 0; c < 40; c++) tick({1'b1, 3'($urandom)}, 1'b0);
    cmp("hold_grant", 32'({bus.valid, bus.grant, bus.grant_id}), 32'({1'b1, hold_grant, 2'd3}));
    cmp("hold_no_error", 32'(bus.error), 32'(0));
`endif

    // Reset mid-grant drops everything with no rearm pulse
    do_reset();
    tick(4'b0010, 1'b0);
    tick(4'b0010, 1'b0);
    cmp("mid_grant", 32'({bus.valid, bus.grant_id}), 32'({1'b1, 2'd1}));
    #2 rst = 1'b1;
    #1;
    cmp("async_reset", 32'({bus.valid, bus.grant, bus.grant_id, bus.rearm, bus.state}), 32'(0));
    @(posedge clk);
    #1;
    cmp("reset_no_rearm", 32'(bus.rearm), 32'(0));
    model_reset();
    rst = 1'b0;
    tick(4'b0010, 1'b0);
    cmp("release_idle", 32'(obs()), 32'(model_out()));
    tick(4'b0010, 1'b0);
    cmp("release_edge_grant", 32'({bus.valid, bus.grant, bus.grant_id}), 32'({1'b1, 4'b0010, 2'd1}));

    // Random traffic against the reference model
    do_reset();
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      r = r ^ N'($urandom & $urandom);
      tick(r, $urandom_range(0, 9) < 3);
      cmp($sformatf("rand%0d", c), 32'(obs()), 32'(model_out()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/abro_event_arbiter.md
ABRO_EVENT_ARBITER -- requirements
Module: abro_event_arbiter

Interface
REQ-001 Parameter N, default 4: number of ABRO channels sharing the service port (2..16).
REQ-002 Parameter TIMEOUT, default 16: max GRANT cycles awaiting Ack (timeout build only).
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Req  input  N  O outputs of N ABRO machines, level, one bit per channel.
REQ-006 Ack  input  1  consumer accepts current grant; sampled only in GRANT.
REQ-007 Valid  output  1  a grant is presented.
REQ-008 Grant  output  N  one-hot grant, all-zero when Valid=0.
REQ-009 GrantId  output  clog2(N)  index of granted channel; 0 when Valid=0.
REQ-010 Rearm  output  N  one-cycle pulse resetting the serviced ABRO channel.
REQ-011 State  output  2  FSM state: IDLE 2'b00, GRANT 2'b01, REARM 2'b10.
REQ-012 Error  output  1  sticky timeout flag.

Function
REQ-013 Per-channel Pending SHALL set on a sampled rising edge of Req[i] (ReqPrev=0, Req=1), registered.
REQ-014 Pending[i] SHALL clear on the edge leaving REARM for channel i; a simultaneous new edge on Req[i] wins (Pending stays 1).
REQ-015 IDLE: if any Pending, SHALL select first Pending at or above Ptr (wrapping N-1→0) and enter GRANT next edge; else stay IDLE.
REQ-016 Latency: Req[i] first sampled high at edge k with arbiter idle → Valid=1, Grant[i]=1 after edge k+1.
REQ-017 GRANT: Valid, Grant, GrantId held stable until Ack sampled 1; then enter REARM.
REQ-018 REARM: exactly one cycle, Valid=0, Rearm[GrantId]=1, all other Rearm bits 0; Ptr ← GrantId+1 mod N; next state IDLE.
REQ-019 Ack sampled in IDLE or REARM SHALL be ignored.
REQ-020 Back-to-back: minimum 3 cycles between successive grant starts (GRANT, REARM, IDLE).
REQ-021 State 2'b11 SHALL return to IDLE next edge with all outputs deasserted.
REQ-022 Req changes during GRANT SHALL not alter the current grant.

Reset
REQ-023 On Reset: State=IDLE, Valid=0, Grant=0, GrantId=0, Rearm=0, Error=0, Pending=0, ReqPrev=0, Ptr=0, timeout counter=0.
REQ-024 Reset mid-GRANT SHALL drop grant without a Rearm pulse.
REQ-025 Req already high at Reset release SHALL count as a rising edge on the first sampled edge.

Configuration
REQ-026 Macro ABRO_ARB_TIMEOUT_EN defined: counter runs in GRANT; Ack absent after TIMEOUT cycles → REARM entered as if acked, Error set until Reset.
REQ-027 Macro undefined: GRANT waits indefinitely; Error tied 0; no counter logic.

Structure
REQ-028 Package abro_arb_pkg SHALL hold state typedef/encodings, N and TIMEOUT defaults.
REQ-029 Sub-module abro_rr_picker: combinational round-robin picker (Pending, Ptr → found, index).

Verification
REQ-030 Reset, Req=0 for 20 cycles → State=00, Valid=0, Rearm=0 throughout.
REQ-031 Req=4'b0100 rises at edge k, Ack 3 cycles later → Grant=0100, GrantId=2 from k+1; Rearm=0100 one cycle; Ptr=3.
REQ-032 Req=4'b1111 together, Ack immediately each grant → GrantId order 0,1,2,3; repeat edges → 0,1,2,3 again.
REQ-033 Ptr=3, Pending=4'b0001 → GrantId=0 (wrap-around).
REQ-034 Timeout build, TIMEOUT=16, no Ack → REARM after 16 GRANT cycles, Error=1 until Reset.
REQ-035 Reset asserted mid-GRANT → outputs zero asynchronously, no Rearm pulse, State=00.
